// File: rtl/input_port.sv
// Router input port: circular flit buffer, XY route computation and credit return.
// Optional accepted-flit statistics counter enabled by defining INPUT_PORT_STATS_EN.
module input_port #(
    parameter int unsigned DEPTH = 5,
    parameter logic [1:0]  MY_X  = 2'd0,
    parameter logic [1:0]  MY_Y  = 2'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data_i,
    input  logic        valid_i,
    output logic [15:0] data_o,
    output logic [4:0]  req_o,
    input  logic        grant_i,
    output logic        credit_o,
    output logic        overflow_o,
    output logic [2:0]  count_o,
    output logic [15:0] flit_cnt_o
);

    localparam int unsigned   PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);
    localparam logic [2:0]    FULL_CNT = 3'(DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUTE = 2'd1;
    localparam logic [1:0] REQ   = 2'd2;

    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [2:0]    count;
    logic [2:0]    count_next;
    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [4:0]    route_q;
    logic [4:0]    route_d;
    logic [15:0]   head_flit;
    logic [1:0]    dest_x;
    logic [1:0]    dest_y;
    logic          pop;
    logic          wr;
    logic          full;
    logic          drop;
    logic          credit_q;
    logic          overflow_q;

    function automatic logic [PW-1:0] adv(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    // A pop in the same cycle frees the slot, so a write into a full buffer is accepted then.
    always_comb begin
        full       = (count == FULL_CNT);
        pop        = (state == REQ) && grant_i;
        wr         = valid_i && (!full || pop);
        drop       = valid_i && full && !pop;
        count_next = count + 3'(wr) - 3'(pop);
    end

    always_comb begin
        head_flit = mem[head];
        dest_x    = head_flit[15:14];
        dest_y    = head_flit[13:12];
        if (dest_x > MY_X)      route_d = 5'b00010;
        else if (dest_x < MY_X) route_d = 5'b01000;
        else if (dest_y > MY_Y) route_d = 5'b00001;
        else if (dest_y < MY_Y) route_d = 5'b00100;
        else                    route_d = 5'b10000;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (count != '0) state_next = ROUTE;
            ROUTE:   state_next = REQ;
            REQ:     if (grant_i) state_next = (count_next != '0) ? ROUTE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            state      <= IDLE;
            route_q    <= '0;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state    <= state_next;
            count    <= count_next;
            credit_q <= pop;
            if (wr)  tail <= adv(tail);
            if (pop) head <= adv(head);
            if (drop) overflow_q <= 1'b1;
            if (state == ROUTE) route_q <= route_d;
        end
    end

    // Storage carries no reset; occupancy gates every read of it.
    always_ff @(posedge clk) begin
        if (rst_n && wr) mem[tail] <= data_i;
    end

    assign data_o     = (count != '0) ? head_flit : '0;
    assign req_o      = (state == REQ) ? route_q : '0;
    assign credit_o   = credit_q;
    assign overflow_o = overflow_q;
    assign count_o    = count;

`ifdef INPUT_PORT_STATS_EN
    logic [15:0] flit_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            flit_cnt <= '0;
        else if (wr && flit_cnt != '1)
            flit_cnt <= flit_cnt + 16'd1;
    end

    assign flit_cnt_o = flit_cnt;
`else
    assign flit_cnt_o = '0;
`endif

endmodule

// File: tb/tb_input_port.sv
// Randomized and directed bench for input_port against a queue-based reference model.
module tb_input_port;

    localparam int unsigned DEPTH = 5;
    localparam int          MX    = 1;
    localparam int          MYC   = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_i = '0;
    logic        valid_i = 1'b0;
    logic [15:0] data_o;
    logic [4:0]  req_o;
    logic        grant_i = 1'b0;
    logic        credit_o;
    logic        overflow_o;
    logic [2:0]  count_o;
    logic [15:0] flit_cnt_o;

    input_port #(.DEPTH(DEPTH), .MY_X(2'd1), .MY_Y(2'd1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .data_o     (data_o),
        .req_o      (req_o),
        .grant_i    (grant_i),
        .credit_o   (credit_o),
        .overflow_o (overflow_o),
        .count_o    (count_o),
        .flit_cnt_o (flit_cnt_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: FIFO contents, edges until the head is requested (-1: nothing scheduled).
    logic [15:0] q[$];
    int          wait_n = -1;
    bit          m_ovf = 0;
    bit          m_credit = 0;
    int          m_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] xy(input logic [15:0] f);
        int dx;
        int dy;
        dx = int'(f[15:14]);
        dy = int'(f[13:12]);
        if (dx > MX)       return 5'b00010;
        else if (dx < MX)  return 5'b01000;
        else if (dy > MYC) return 5'b00001;
        else if (dy < MYC) return 5'b00100;
        else               return 5'b10000;
    endfunction

    task automatic step(input bit r, input bit v, input logic [15:0] d, input bit g);
        bit pop;
        bit full;
        bit acc;
        int pre;
        logic [4:0]  exp_req;
        logic [15:0] exp_data;
        logic [15:0] exp_fc;
        rst_n   = r;
        valid_i = v;
        data_i  = d;
        grant_i = g;
        if (!r) begin
            q.delete();
            wait_n   = -1;
            m_ovf    = 0;
            m_credit = 0;
            m_cnt    = 0;
        end else begin
            pre  = q.size();
            pop  = (wait_n == 0) && g;
            full = (pre == DEPTH);
            acc  = v && (!full || pop);
            if (v && full && !pop) m_ovf = 1;
            if (pop) void'(q.pop_front());
            if (acc) begin
                q.push_back(d);
                if (m_cnt < 65535) m_cnt++;
            end
            m_credit = pop;
            if (pop)                     wait_n = (q.size() > 0) ? 1 : -1;
            else if (wait_n > 0)         wait_n--;
            else if (wait_n < 0 && pre > 0) wait_n = 1;
        end
        @(negedge clk);
        exp_req  = (wait_n == 0) ? xy(q[0]) : 5'b0;
        exp_data = (q.size() > 0) ? q[0] : 16'h0000;
`ifdef INPUT_PORT_STATS_EN
        exp_fc = 16'(m_cnt);
`else
        exp_fc = 16'h0000;
`endif
        check("req_o",      32'(req_o),      32'(exp_req));
        check("data_o",     32'(data_o),     32'(exp_data));
        check("count_o",    32'(count_o),    32'(q.size()));
        check("credit_o",   32'(credit_o),   32'(m_credit));
        check("overflow_o", 32'(overflow_o), 32'(m_ovf));
        check("flit_cnt_o", 32'(flit_cnt_o), 32'(exp_fc));
    endtask

    task automatic idle(input int n, input bit g);
        for (int i = 0; i < n; i++) step(1, 0, 16'h0000, g);
    endtask

    initial begin
        @(negedge clk);
        step(0, 0, 16'h0000, 0);
        step(0, 0, 16'h0000, 0);

        // Single eastbound flit, then a grant once it is requested
        step(1, 1, 16'h8ABC, 0);
        idle(2, 0);
        check("e_route", 32'(req_o), 32'(5'b00010));
        step(1, 0, 16'h0000, 1);
        idle(3, 0);

        // Two local flits back-to-back with grant held high
        step(1, 1, 16'h5001, 1);
        step(1, 1, 16'h5002, 1);
        idle(8, 1);

        // Overfill without grant, then drain
        for (int i = 1; i <= 6; i++) step(1, 1, 16'(16'h1000 + i), 0);
        idle(3, 0);
        check("ovf_sticky", 32'(overflow_o), 32'(1));
        idle(14, 1);

        // Full buffer with simultaneous write and grant
        step(0, 0, 16'h0000, 0);
        for (int i = 1; i <= 5; i++) step(1, 1, 16'(16'h2000 + i), 0);
        for (int i = 0; i < 10 && wait_n != 0; i++) step(1, 0, 16'h0000, 0);
        check("full_req_ready", 32'(wait_n), 32'(0));
        step(1, 1, 16'h9F00, 1);
        check("full_cnt_kept", 32'(count_o), 32'(DEPTH));
        idle(16, 1);

        // Reset with flits buffered and overflow set
        for (int i = 1; i <= 7; i++) step(1, 1, 16'(16'h3000 + i), 0);
        step(0, 0, 16'h0000, 1);
        check("rst_count", 32'(count_o), 32'(0));
        idle(3, 1);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(199) != 0, $urandom_range(1) == 1,
                 16'($urandom()), $urandom_range(2) != 0);
        end
        idle(20, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
